// File: rtl/rtp_collect_pkg.sv
// Shared types for the ray-tracing result collector: run FSM states and record layout.
package rtp_collect_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int REC_DATA_W = 32;
    localparam int REC_ID_W   = 32;
    localparam int REC_CH_W   = 4;

    typedef struct packed {
        logic [REC_DATA_W-1:0] hit_t;
        logic [REC_ID_W-1:0]   ray_id;
        logic [REC_CH_W-1:0]   ch;
    } rec_t;

    // Channel index width, never narrower than one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rtp_collect_fifo.sv
// Synchronous record FIFO with a registered head; the head holds its last value when empty.
module rtp_collect_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;
    logic [AW:0]      rd_ptr_nxt_s;
    logic [AW:0]      occ_after_pop_s;

    assign count           = wr_ptr_r - rd_ptr_r;
    assign full            = (count == (AW+1)'(DEPTH));
    assign empty           = (count == {(AW+1){1'b0}});
    assign do_push_s       = push & ~full;
    assign do_pop_s        = pop & ~empty;
    assign rd_ptr_nxt_s    = rd_ptr_r + {{AW{1'b0}}, do_pop_s};
    assign occ_after_pop_s = count - {{AW{1'b0}}, do_pop_s};

    // Storage array write port.
    always_ff @(posedge clock) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

    // Pointers and head register; a push into an (effectively) empty FIFO bypasses to the head.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r  <= {(AW+1){1'b0}};
            rd_ptr_r  <= {(AW+1){1'b0}};
            head_data <= {WIDTH{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_nxt_s;
            end
            if (occ_after_pop_s == {(AW+1){1'b0}}) begin
                if (do_push_s) begin
                    head_data <= push_data;
                end
            end else begin
                head_data <= mem_r[rd_ptr_nxt_s[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/rtp_result_collector.sv
// Multi-channel result collector: round-robin arbitration into a FIFO plus run monitor.
// Optional per-channel accept counters are enabled with RTP_COLLECT_PERCH_CNT_EN.
module rtp_result_collector
    import rtp_collect_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = 32,
    parameter int ID_W       = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 64,
    localparam int CH_W      = ch_width(NUM_CH)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     io_start,
    input  logic [NUM_CH-1:0]        io_ch_valid,
    output logic [NUM_CH-1:0]        io_ch_ready,
    input  logic [NUM_CH*DATA_W-1:0] io_ch_hitT,
    input  logic [NUM_CH*ID_W-1:0]   io_ch_ray_id,
    input  logic [NUM_CH-1:0]        io_ch_finish,
    output logic                     io_out_valid,
    input  logic                     io_out_ready,
    output logic [DATA_W-1:0]        io_out_hitT,
    output logic [ID_W-1:0]          io_out_ray_id,
    output logic [CH_W-1:0]          io_out_ch,
    output logic                     io_all_finish,
    output logic [CNT_W-1:0]         io_total_cycle,
    output logic [CNT_W-1:0]         io_result_count,
    output logic                     io_overflow
`ifdef RTP_COLLECT_PERCH_CNT_EN
    ,
    output logic [NUM_CH*CNT_W-1:0]  io_ch_count
`endif
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int REC_W = DATA_W + ID_W + CH_W;

    state_e              state_r;
    logic [NUM_CH-1:0]   finish_latch_r;
    logic [CH_W-1:0]     rr_ptr_r;
    logic [CH_W-1:0]     grant_idx_s;
    logic                grant_valid_s;
    logic                accept_s;
    logic [NUM_CH-1:0]   eligible_s;
    logic [NUM_CH-1:0]   viol_s;
    logic [REC_W-1:0]    push_rec_s;
    logic [REC_W-1:0]    head_rec_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [AW:0]         fifo_count_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign eligible_s = (state_r == ST_RUN) ? (io_ch_valid & ~finish_latch_r) : {NUM_CH{1'b0}};
    assign viol_s     = io_ch_valid & ((state_r == ST_RUN) ? finish_latch_r : {NUM_CH{1'b1}});
    assign accept_s   = grant_valid_s & ~fifo_full_s;
    assign push_rec_s = {io_ch_hitT[int'(grant_idx_s)*DATA_W +: DATA_W],
                         io_ch_ray_id[int'(grant_idx_s)*ID_W +: ID_W],
                         grant_idx_s};

    // Round-robin search starting at the channel after the last accepted one.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = {CH_W{1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            logic [CH_W-1:0] idx_v;
            idx_v = CH_W'((int'(rr_ptr_r) + k) % NUM_CH);
            if (!grant_valid_s && eligible_s[idx_v]) begin
                grant_valid_s = 1'b1;
                grant_idx_s   = idx_v;
            end else begin
                grant_valid_s = grant_valid_s;
            end
        end
    end

    // Ready is a one-hot of the grant, suppressed while the FIFO is full.
    always_comb begin
        io_ch_ready = {NUM_CH{1'b0}};
        if (accept_s) begin
            io_ch_ready[grant_idx_s] = 1'b1;
        end else begin
            io_ch_ready = {NUM_CH{1'b0}};
        end
    end

    rtp_collect_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (accept_s),
        .push_data (push_rec_s),
        .pop       (io_out_ready),
        .head_data (head_rec_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    assign io_out_valid  = ~fifo_empty_s;
    assign io_out_hitT   = head_rec_s[REC_W-1 -: DATA_W];
    assign io_out_ray_id = head_rec_s[CH_W +: ID_W];
    assign io_out_ch     = head_rec_s[CH_W-1:0];

    // Run FSM with finish latches, counters and protocol-violation flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            finish_latch_r  <= {NUM_CH{1'b0}};
            rr_ptr_r        <= {CH_W{1'b0}};
            io_all_finish   <= 1'b0;
            io_total_cycle  <= {CNT_W{1'b0}};
            io_result_count <= {CNT_W{1'b0}};
            io_overflow     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (io_start) begin
                        state_r         <= ST_RUN;
                        finish_latch_r  <= {NUM_CH{1'b0}};
                        rr_ptr_r        <= {CH_W{1'b0}};
                        io_all_finish   <= 1'b0;
                        io_total_cycle  <= {CNT_W{1'b0}};
                        io_result_count <= {CNT_W{1'b0}};
                        io_overflow     <= 1'b0;
                    end else begin
                        io_overflow <= io_overflow | (|viol_s);
                    end
                end
                ST_RUN: begin
                    io_total_cycle <= sat_inc(io_total_cycle);
                    finish_latch_r <= finish_latch_r | io_ch_finish;
                    io_overflow    <= io_overflow | (|viol_s);
                    if (accept_s) begin
                        io_result_count <= sat_inc(io_result_count);
                        rr_ptr_r        <= (grant_idx_s == CH_W'(NUM_CH - 1)) ?
                                           {CH_W{1'b0}} : grant_idx_s + CH_W'(1);
                    end
                    if (&finish_latch_r) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    io_total_cycle <= sat_inc(io_total_cycle);
                    finish_latch_r <= finish_latch_r | io_ch_finish;
                    io_overflow    <= io_overflow | (|viol_s);
                    if (fifo_count_s == {(AW+1){1'b0}}) begin
                        state_r       <= ST_DONE;
                        io_all_finish <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef RTP_COLLECT_PERCH_CNT_EN
    // Per-channel accepted-record counters; accepts only happen in RUN, so DONE freezes them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_ch_count <= {(NUM_CH*CNT_W){1'b0}};
        end else if ((state_r == ST_IDLE || state_r == ST_DONE) && io_start) begin
            io_ch_count <= {(NUM_CH*CNT_W){1'b0}};
        end else if (accept_s) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (grant_idx_s == CH_W'(i)) begin
                    io_ch_count[i*CNT_W +: CNT_W] <= sat_inc(io_ch_count[i*CNT_W +: CNT_W]);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_rtp_result_collector.sv
// Scoreboard bench for rtp_result_collector: directed scenarios plus randomized traffic.
module tb_rtp_result_collector;

    localparam int NUM_CH     = 2;
    localparam int DATA_W     = 32;
    localparam int ID_W       = 32;
    localparam int FIFO_DEPTH = 8;
    localparam int CNT_W      = 64;
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                     clock;
    logic                     reset;
    logic                     io_start;
    logic [NUM_CH-1:0]        io_ch_valid;
    logic [NUM_CH-1:0]        io_ch_ready;
    logic [NUM_CH*DATA_W-1:0] io_ch_hitT;
    logic [NUM_CH*ID_W-1:0]   io_ch_ray_id;
    logic [NUM_CH-1:0]        io_ch_finish;
    logic                     io_out_valid;
    logic                     io_out_ready;
    logic [DATA_W-1:0]        io_out_hitT;
    logic [ID_W-1:0]          io_out_ray_id;
    logic [CH_W-1:0]          io_out_ch;
    logic                     io_all_finish;
    logic [CNT_W-1:0]         io_total_cycle;
    logic [CNT_W-1:0]         io_result_count;
    logic                     io_overflow;
`ifdef RTP_COLLECT_PERCH_CNT_EN
    logic [NUM_CH*CNT_W-1:0]  io_ch_count;
`endif

    rtp_result_collector #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ID_W(ID_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset), .io_start(io_start),
        .io_ch_valid(io_ch_valid), .io_ch_ready(io_ch_ready),
        .io_ch_hitT(io_ch_hitT), .io_ch_ray_id(io_ch_ray_id), .io_ch_finish(io_ch_finish),
        .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
        .io_out_hitT(io_out_hitT), .io_out_ray_id(io_out_ray_id), .io_out_ch(io_out_ch),
        .io_all_finish(io_all_finish), .io_total_cycle(io_total_cycle),
        .io_result_count(io_result_count), .io_overflow(io_overflow)
`ifdef RTP_COLLECT_PERCH_CNT_EN
        , .io_ch_count(io_ch_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [DATA_W-1:0] hit;
        logic [ID_W-1:0]   id;
        int                ch;
    } exp_rec_t;

    exp_rec_t exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    // Reference model of the run monitor.
    bit                m_run, m_drain, m_allfin, m_ovf;
    logic [NUM_CH-1:0] m_latch;
    int                m_rr;
    longint unsigned   m_tc, m_rc;
    longint unsigned   m_chc[NUM_CH];
    logic [ID_W-1:0]   last_id;

    // Stimulus for the next cycle.
    bit                d_start, d_ready;
    logic [NUM_CH-1:0] d_valid, d_finish;
    logic [DATA_W-1:0] d_hit[NUM_CH];
    logic [ID_W-1:0]   d_id[NUM_CH];
    int unsigned       next_id;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_run = 1'b0; m_drain = 1'b0; m_allfin = 1'b0; m_ovf = 1'b0;
        m_latch = '0; m_rr = 0; m_tc = 0; m_rc = 0;
        for (int i = 0; i < NUM_CH; i++) m_chc[i] = 0;
    endtask

    task automatic cycle();
        int g;
        int occ;
        bit acc;
        logic [NUM_CH-1:0] exp_rdy;
        exp_rec_t r;
        @(negedge clock);
        io_start = d_start; io_ch_valid = d_valid; io_ch_finish = d_finish; io_out_ready = d_ready;
        for (int i = 0; i < NUM_CH; i++) begin
            io_ch_hitT[i*DATA_W +: DATA_W] = d_hit[i];
            io_ch_ray_id[i*ID_W +: ID_W]   = d_id[i];
        end
        #1;
        chk("all_finish", io_all_finish, m_allfin);
        chk("total_cycle", io_total_cycle, m_tc);
        chk("result_count", io_result_count, m_rc);
        chk("overflow", io_overflow, m_ovf);
`ifdef RTP_COLLECT_PERCH_CNT_EN
        for (int i = 0; i < NUM_CH; i++) chk("ch_count", io_ch_count[i*CNT_W +: CNT_W], m_chc[i]);
`endif
        occ = exp_q.size();
        g = -1;
        if (m_run) begin
            for (int k = 0; k < NUM_CH; k++) begin
                int idx;
                idx = (m_rr + k) % NUM_CH;
                if (g < 0 && d_valid[idx] && !m_latch[idx]) g = idx;
            end
        end
        acc = (g >= 0) && (occ < FIFO_DEPTH);
        exp_rdy = '0;
        if (acc) exp_rdy[g] = 1'b1;
        chk("ch_ready", io_ch_ready, exp_rdy);
        #2;
        if (acc) begin
            r.hit = d_hit[g]; r.id = d_id[g]; r.ch = g;
            exp_q.push_back(r);
            m_rc++; m_chc[g]++;
            m_rr = (g + 1) % NUM_CH;
            d_hit[g] = $urandom;
            d_id[g] = next_id;
            next_id++;
        end
        if (m_run || m_drain) m_tc++;
        if (!m_run && !m_drain) begin
            if (d_start) begin
                model_clear();
                m_run = 1'b1;
            end else begin
                m_ovf = m_ovf | (|d_valid);
            end
        end else if (m_run) begin
            m_ovf = m_ovf | (|(d_valid & m_latch));
            if (&m_latch) begin
                m_run = 1'b0; m_drain = 1'b1;
            end
            m_latch = m_latch | d_finish;
        end else begin
            m_ovf = m_ovf | (|d_valid);
            m_latch = m_latch | d_finish;
            if (occ == 0) begin
                m_drain = 1'b0; m_allfin = 1'b1;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic pulse_start();
        d_start = 1'b1; cycle(); d_start = 1'b0;
    endtask

    task automatic mid_reset();
        @(posedge clock); #2;
        chk("pre_rst_out_valid", io_out_valid, 1'b1);
        reset = 1'b1;
        #1;
        chk("rst_out_valid", io_out_valid, 1'b0);
        chk("rst_ch_ready", io_ch_ready, '0);
        chk("rst_result_count", io_result_count, '0);
        chk("rst_total_cycle", io_total_cycle, '0);
        exp_q.delete();
        model_clear();
        last_id = '0;
        d_valid = '0; d_finish = '0;
        io_ch_valid = '0; io_ch_finish = '0; io_start = 1'b0;
        @(negedge clock); #4;
        reset = 1'b0;
    endtask

    // Monitor: compare the FIFO head against the scoreboard and retire popped records.
    initial begin
        forever begin
            @(negedge clock); #2;
            if (!reset) begin
                chk("out_valid", io_out_valid, exp_q.size() != 0);
                if (exp_q.size() != 0) begin
                    chk("out_ray_id", io_out_ray_id, exp_q[0].id);
                    chk("out_hitT", io_out_hitT, exp_q[0].hit);
                    chk("out_ch", io_out_ch, exp_q[0].ch);
                    last_id = exp_q[0].id;
                    if (io_out_ready) void'(exp_q.pop_front());
                end else begin
                    chk("out_hold_id", io_out_ray_id, last_id);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; io_start = 1'b0; io_ch_valid = '0; io_ch_finish = '0; io_out_ready = 1'b0;
        io_ch_hitT = '0; io_ch_ray_id = '0;
        d_start = 1'b0; d_ready = 1'b0; d_valid = '0; d_finish = '0;
        for (int i = 0; i < NUM_CH; i++) begin d_hit[i] = $urandom; d_id[i] = 32'd100 + i; end
        model_clear();
        last_id = '0;
        #1;
        chk("reset_out_valid", io_out_valid, 1'b0);
        chk("reset_ch_ready", io_ch_ready, '0);
        chk("reset_out_ray_id", io_out_ray_id, '0);
        chk("reset_out_hitT", io_out_hitT, '0);
        chk("reset_out_ch", io_out_ch, '0);
        chk("reset_all_finish", io_all_finish, 1'b0);
        chk("reset_overflow", io_overflow, 1'b0);
        chk("reset_result_count", io_result_count, '0);
        @(negedge clock); #4;
        reset = 1'b0;

        // ch0 sends ids 1,2,3 with the consumer always ready.
        pulse_start();
        d_id[0] = 32'd1; next_id = 32'd2;
        d_valid = 2'b01; d_ready = 1'b1;
        run(3);
        d_valid = 2'b00;
        run(2);
        chk("t1_result_count", io_result_count, 64'd3);

        // Two records queued when both finishes arrive; completion waits for the pops.
        d_ready = 1'b0;
        d_valid = 2'b11; run(1);
        d_valid = 2'b01; run(1);
        d_valid = 2'b00; d_finish = 2'b11; run(1);
        d_finish = 2'b00; run(3);
        chk("drain_not_done", io_all_finish, 1'b0);
        d_ready = 1'b1; run(4);
        chk("drain_done", io_all_finish, 1'b1);
        run(3);

        // Both channels valid every cycle: grants alternate.
        pulse_start();
        d_valid = 2'b11; d_ready = 1'b1;
        run(8);

        // Consumer stalled: FIFO fills to depth, then one pop lets one more in.
        d_ready = 1'b0; d_valid = 2'b01;
        run(10);
        chk("full_no_ready", io_ch_ready, 2'b00);
        d_ready = 1'b1; run(1);
        d_ready = 1'b0; run(2);

        // ch1 keeps sending after its finish: overflow, then cleared by a new start.
        d_valid = 2'b00; d_finish = 2'b10; run(1);
        d_finish = 2'b00; d_valid = 2'b10; run(2);
        chk("t5_overflow", io_overflow, 1'b1);
        d_valid = 2'b00; d_finish = 2'b01; run(1);
        d_finish = 2'b00; d_ready = 1'b1; run(14);
        pulse_start();
        run(1);
        chk("restart_overflow", io_overflow, 1'b0);
        chk("restart_result_count", io_result_count, '0);

        // Randomized traffic with random backpressure and late finishes.
        for (int c = 0; c < 400; c++) begin
            d_valid = NUM_CH'($urandom);
            d_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NUM_CH; i++) d_finish[i] = (c > 300) && ($urandom_range(0, 19) == 0);
            cycle();
        end
        d_valid = '0; d_finish = '1; run(1);
        d_finish = '0; d_ready = 1'b1; run(15);
        chk("rand_done", io_all_finish, 1'b1);

        // Asynchronous reset with four records queued.
        pulse_start();
        d_ready = 1'b0; d_valid = 2'b01;
        run(4);
        mid_reset();
        pulse_start();
        d_valid = 2'b01; d_ready = 1'b1; run(3);
        d_valid = 2'b00; d_finish = 2'b11; run(1);
        d_finish = 2'b00; run(6);
        chk("final_done", io_all_finish, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rtp_result_collector.md
# rtp_result_collector

Parametrised multi-channel result collector and run monitor for the ray-tracing processor. It sits between NUM_CH ray-traversal cores and the host/bench side. It accepts per-core (ray_id, hitT) result records through valid/ready handshakes, arbitrates them round-robin into one FIFO, counts run cycles and accepted results, and raises a single all-finish flag once every core has finished and the FIFO has drained. It generalises the single-core hitT / ray_id / finish / cycle-count observation path to N cores with buffering and backpressure.

## Interface
Parameters:
- NUM_CH, 2: number of core channels (1..16)
- DATA_W, 32: hitT width (raw IEEE-754 bits, not interpreted)
- ID_W, 32: ray/triangle id width
- FIFO_DEPTH, 8: record FIFO depth; power of two, ≥2
- CNT_W, 64: cycle and result counter width

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- io_start  in  1  pulse; starts a run
- io_ch_valid  in  NUM_CH  per-channel record valid
- io_ch_ready  out  NUM_CH  per-channel record accepted this cycle
- io_ch_hitT  in  NUM_CH*DATA_W  packed, channel 0 in LSBs
- io_ch_ray_id  in  NUM_CH*ID_W  packed, channel 0 in LSBs
- io_ch_finish  in  NUM_CH  per-channel finish level/pulse
- io_out_valid  out  1  FIFO head valid
- io_out_ready  in  1  consumer pop
- io_out_hitT  out  DATA_W  head record hitT
- io_out_ray_id  out  ID_W  head record id
- io_out_ch  out  $clog2(NUM_CH) (min 1)  source channel of head
- io_all_finish  out  1  run complete
- io_total_cycle  out  CNT_W  cycles spent in RUN+DRAIN
- io_result_count  out  CNT_W  records accepted this run
- io_overflow  out  1  sticky protocol-violation flag

## Operation
- FSM: IDLE, RUN, DRAIN, DONE. Reset → IDLE.
- IDLE/DONE + io_start → RUN; clears counters, finish latches, io_overflow, io_all_finish. FIFO contents are kept (drained already in DONE). io_start is ignored in RUN and DRAIN.
- RUN: round-robin arbiter over channels with valid=1 and finish latch=0. The pointer starts after the last granted channel, and channel 0 has priority after reset/start. Exactly one grant per cycle. io_ch_ready[g]=1 only for the granted channel and only when the FIFO is not full. Accept = valid & ready: push {hitT, ray_id, ch}, result_count+1.
- io_ch_finish[i]=1 sets a sticky latch. A record valid in the same cycle as finish is still eligible.
- All latches set (evaluated on registered latches) → DRAIN. No accepts in DRAIN.
- DRAIN + FIFO empty → DONE; io_all_finish=1, counters frozen.
- Pop = io_out_valid & io_out_ready, in any state.
- io_total_cycle increments every cycle in RUN and DRAIN and saturates at all-ones. io_result_count saturates likewise.
- io_overflow sets on io_ch_valid[i]=1 while in IDLE, DRAIN or DONE, or after that channel's finish latch is set.

## Timing
- Reset values: io_ch_ready=0, io_out_valid=0, io_out_hitT/ray_id/ch=0, io_all_finish=0, counters=0, io_overflow=0, FIFO empty.
- io_ch_ready is combinational from the registered state, latches, FIFO count and io_ch_valid.
- Push-to-output latency is 1 cycle: a record accepted at edge N is at the head after N when the FIFO was empty.
- Full FIFO: no accept even if a pop occurs in the same cycle. Empty FIFO: io_out_valid=0, and io_out_* hold their last values.
- FIFO pointers wrap modulo FIFO_DEPTH, with an extra wrap bit for the full/empty distinction.
- An asynchronous reset mid-run discards FIFO contents and returns to IDLE immediately.

## Configuration
- RTP_COLLECT_PERCH_CNT_EN defined: adds output io_ch_count (NUM_CH*CNT_W), a per-channel accepted-record counter. It is cleared on start, saturates, and is frozen in DONE.
- Not defined: the port and counters are absent; all other behaviour is identical.

## Structure
- Package rtp_collect_pkg: FSM state enum (IDLE/RUN/DRAIN/DONE) and the record struct typedef parametrised via localparams.
- Sub-module rtp_collect_fifo: synchronous FIFO with full/empty/count outputs. Arbiter and FSM stay in the top module.

## Test plan
- Reset, start, ch0 sends 3 records (ids 1,2,3), io_out_ready=1 → outputs ids 1,2,3 in order, each 1 cycle after accept; result_count=3.
- NUM_CH=2, both valid every cycle → grants alternate 0,1,0,1 and io_out_ch alternates.
- io_out_ready=0, 10 records offered, FIFO_DEPTH=8 → exactly 8 accepted, ready low while full. Then pop one → one more accepted the following cycle.
- Both finishes raised with 2 records queued → DRAIN. io_all_finish rises only after both records pop; io_total_cycle is then frozen.
- ch1 asserts valid after its finish → io_ch_ready[1]=0 and io_overflow=1. A second io_start clears io_overflow and the counters.
- Reset asserted mid-RUN with 4 records queued → io_out_valid=0 and state IDLE without waiting for a clock edge.
